cdb_arbiter: RTL and testbench

//   Stage directly upstream of the common data bus. Captures completed results from
//   FU_NUM functional units, one holding register per FU, and grants one per cycle

---
 rtl/cdb_arbiter.sv | 110 +++++++++++
 tb/tb_cdb_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Result holding stage in front of the common data bus. It buffers one result per
// functional unit and grants one buffered result per cycle in round-robin order.
module cdb_arbiter #(
    parameter int FU_NUM      = 4,
    parameter int XLEN        = 32,
    parameter int ROB_TAG_LEN = 5,
    parameter int BTU_IDX     = 3,
    localparam int SEL_W      = $clog2(FU_NUM)
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic [FU_NUM-1:0]        fu_valid,
    input  logic [FU_NUM*XLEN-1:0]   fu_value,
    input  logic [FU_NUM*ROB_TAG_LEN-1:0] fu_rob_tag,
    input  logic                     fu_mispredict,
    input  logic [XLEN-1:0]          fu_pc,
    output logic [FU_NUM-1:0]        fu_ready,
    output logic                     cdb_select_flag,
    output logic [SEL_W-1:0]         cdb_select_signal,
    output logic [ROB_TAG_LEN-1:0]   cdb_rob_tag,
    output logic [FU_NUM*XLEN-1:0]   cdb_values,
    output logic                     cdb_mispredict,
    output logic [XLEN-1:0]          cdb_pc
);

    logic [FU_NUM-1:0]      buf_valid;
    logic [XLEN-1:0]        buf_value [FU_NUM];
    logic [ROB_TAG_LEN-1:0] buf_tag   [FU_NUM];
    logic                   buf_mispredict;
    logic [XLEN-1:0]        buf_pc;
    logic [SEL_W-1:0]       rr_ptr;

    logic                   grant_valid;
    logic [SEL_W-1:0]       grant_idx;
    int                     scan_idx;

    // Scan from the lowest-priority offset down so the slot nearest rr_ptr wins last.
    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        scan_idx    = 0;
        for (int k = FU_NUM - 1; k >= 0; k--) begin
            scan_idx = (int'(rr_ptr) + k) % FU_NUM;
            if (buf_valid[scan_idx]) begin
                grant_valid = 1'b1;
                grant_idx   = SEL_W'(scan_idx);
            end
        end
    end

    // A granted slot drains this cycle, so it may refill at the same edge.
    always_comb begin
        for (int i = 0; i < FU_NUM; i++) begin
            fu_ready[i] = !flush && (!buf_valid[i] || (grant_valid && grant_idx == SEL_W'(i)));
        end
    end

    always_comb begin
        cdb_select_flag   = |buf_valid;
        cdb_select_signal = grant_idx;
        cdb_rob_tag       = grant_valid ? buf_tag[grant_idx] : '0;
        for (int i = 0; i < FU_NUM; i++) begin
            cdb_values[i*XLEN +: XLEN] = buf_value[i];
        end
        if (grant_valid && grant_idx == SEL_W'(BTU_IDX)) begin
            cdb_mispredict = buf_mispredict;
            cdb_pc         = buf_pc;
        end else begin
            cdb_mispredict = 1'b0;
            cdb_pc         = '0;
        end
    end

    // NOTE: the data registers are reset too, because cdb_values is visible ungated.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            buf_valid      <= '0;
            buf_mispredict <= 1'b0;
            buf_pc         <= '0;
            rr_ptr         <= '0;
            for (int i = 0; i < FU_NUM; i++) begin
                buf_value[i] <= '0;
                buf_tag[i]   <= '0;
            end
        end else if (flush) begin
            buf_valid <= '0;
        end else begin
            for (int i = 0; i < FU_NUM; i++) begin
                if (fu_valid[i] && fu_ready[i]) begin
                    buf_valid[i] <= 1'b1;
                    buf_value[i] <= fu_value[i*XLEN +: XLEN];
                    buf_tag[i]   <= fu_rob_tag[i*ROB_TAG_LEN +: ROB_TAG_LEN];
                    if (i == BTU_IDX) begin
                        buf_mispredict <= fu_mispredict;
                        buf_pc         <= fu_pc;
                    end
                end else if (grant_valid && grant_idx == SEL_W'(i)) begin
                    buf_valid[i] <= 1'b0;
                end
            end
            if (grant_valid) begin
                rr_ptr <= (grant_idx == SEL_W'(FU_NUM - 1)) ? '0 : grant_idx + SEL_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, single result, contention, back-to-back,
// branch-unit forwarding, flush and mid-operation reset, all with hand-computed values.
module tb_cdb_arbiter;

    logic         clock;
    logic         reset_n;
    logic         flush;
    logic [3:0]   fu_valid;
    logic [127:0] fu_value;
    logic [19:0]  fu_rob_tag;
    logic         fu_mispredict;
    logic [31:0]  fu_pc;
    logic [3:0]   fu_ready;
    logic         cdb_select_flag;
    logic [1:0]   cdb_select_signal;
    logic [4:0]   cdb_rob_tag;
    logic [127:0] cdb_values;
    logic         cdb_mispredict;
    logic [31:0]  cdb_pc;

    int total = 0;
    int bad   = 0;

    cdb_arbiter dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .flush             (flush),
        .fu_valid          (fu_valid),
        .fu_value          (fu_value),
        .fu_rob_tag        (fu_rob_tag),
        .fu_mispredict     (fu_mispredict),
        .fu_pc             (fu_pc),
        .fu_ready          (fu_ready),
        .cdb_select_flag   (cdb_select_flag),
        .cdb_select_signal (cdb_select_signal),
        .cdb_rob_tag       (cdb_rob_tag),
        .cdb_values        (cdb_values),
        .cdb_mispredict    (cdb_mispredict),
        .cdb_pc            (cdb_pc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_fu(input int idx, input logic v, input logic [4:0] tag,
                          input logic [31:0] value);
        fu_valid[idx]            = v;
        fu_rob_tag[idx*5 +: 5]   = tag;
        fu_value[idx*32 +: 32]   = value;
    endtask

    // Advance one clock edge and settle just after it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset_n       = 1'b0;
        flush         = 1'b0;
        fu_valid      = 4'b1111;
        fu_value      = '0;
        fu_rob_tag    = '0;
        fu_mispredict = 1'b0;
        fu_pc         = '0;

        // Reset held with all FUs presenting results
        step(); step();
        check("rst_flag",  128'(cdb_select_flag), 128'd0);
        check("rst_tag",   128'(cdb_rob_tag), 128'd0);
        check("rst_ready", 128'(fu_ready), 128'hF);
        check("rst_sel",   128'(cdb_select_signal), 128'd0);
        check("rst_vals",  cdb_values, 128'd0);
        check("rst_pc",    128'({cdb_mispredict, cdb_pc}), 128'd0);
        fu_valid = 4'b0000;
        reset_n  = 1'b1;
        step();
        check("idle_flag", 128'(cdb_select_flag), 128'd0);

        // Single result from FU1
        set_fu(1, 1'b1, 5'd7, 32'hDEADBEEF);
        step();
        fu_valid = 4'b0000;
        check("single_flag", 128'(cdb_select_flag), 128'd1);
        check("single_sel",  128'(cdb_select_signal), 128'd1);
        check("single_tag",  128'(cdb_rob_tag), 128'd7);
        check("single_val",  128'(cdb_values[63:32]), 128'hDEADBEEF);
        step();
        check("single_drain", 128'(cdb_select_flag), 128'd0);
        check("single_val_hold", 128'(cdb_values[63:32]), 128'hDEADBEEF);

        // Branch unit alone (rr_ptr=2 here); afterwards rr_ptr=0
        set_fu(3, 1'b1, 5'd9, 32'h0000_00AA);
        fu_mispredict = 1'b1;
        fu_pc         = 32'h0000_1040;
        step();
        fu_valid = 4'b0000;
        check("btu_sel",  128'(cdb_select_signal), 128'd3);
        check("btu_tag",  128'(cdb_rob_tag), 128'd9);
        check("btu_mis",  128'(cdb_mispredict), 128'd1);
        check("btu_pc",   128'(cdb_pc), 128'h1040);
        step();
        check("btu_drain_flag", 128'(cdb_select_flag), 128'd0);
        check("btu_drain_pc",   128'({cdb_mispredict, cdb_pc}), 128'd0);

        // Contention: all four FUs at one edge, rr_ptr=0
        set_fu(0, 1'b1, 5'd10, 32'h1000_0000);
        set_fu(1, 1'b1, 5'd11, 32'h1000_0001);
        set_fu(2, 1'b1, 5'd12, 32'h1000_0002);
        set_fu(3, 1'b1, 5'd13, 32'h1000_0003);
        fu_pc = 32'h0000_2000;
        #1;
        check("cont_ready_empty", 128'(fu_ready), 128'hF);
        step();
        fu_valid = 4'b0000;
        check("cont_g0_sel",   128'(cdb_select_signal), 128'd0);
        check("cont_g0_tag",   128'(cdb_rob_tag), 128'd10);
        check("cont_g0_ready", 128'(fu_ready), 128'b0001);
        check("cont_g0_pc",    128'({cdb_mispredict, cdb_pc}), 128'd0);
        step();
        check("cont_g1_sel",   128'(cdb_select_signal), 128'd1);
        check("cont_g1_tag",   128'(cdb_rob_tag), 128'd11);
        check("cont_g1_ready", 128'(fu_ready), 128'b0011);
        step();
        check("cont_g2_sel",   128'(cdb_select_signal), 128'd2);
        check("cont_g2_tag",   128'(cdb_rob_tag), 128'd12);
        check("cont_g2_ready", 128'(fu_ready), 128'b0111);
        step();
        check("cont_g3_sel",   128'(cdb_select_signal), 128'd3);
        check("cont_g3_tag",   128'(cdb_rob_tag), 128'd13);
        check("cont_g3_mis",   128'(cdb_mispredict), 128'd1);
        check("cont_g3_pc",    128'(cdb_pc), 128'h2000);
        step();
        check("cont_done", 128'(cdb_select_flag), 128'd0);

        // rr_ptr wrapped to 0: FU0 wins over FU1
        set_fu(0, 1'b1, 5'd20, 32'h2);
        set_fu(1, 1'b1, 5'd21, 32'h3);
        step();
        fu_valid = 4'b0000;
        check("wrap_first",  128'(cdb_rob_tag), 128'd20);
        step();
        check("wrap_second", 128'(cdb_rob_tag), 128'd21);
        step();
        check("wrap_done",   128'(cdb_select_flag), 128'd0);

        // Back-to-back from FU2 with tags 1,2,3
        set_fu(2, 1'b1, 5'd1, 32'h51);
        step();
        check("b2b_t1", 128'(cdb_rob_tag), 128'd1);
        check("b2b_r1", 128'(fu_ready[2]), 128'd1);
        set_fu(2, 1'b1, 5'd2, 32'h52);
        step();
        check("b2b_t2", 128'(cdb_rob_tag), 128'd2);
        check("b2b_r2", 128'(fu_ready[2]), 128'd1);
        set_fu(2, 1'b1, 5'd3, 32'h53);
        step();
        fu_valid = 4'b0000;
        check("b2b_t3",  128'(cdb_rob_tag), 128'd3);
        check("b2b_val", 128'(cdb_values[95:64]), 128'h53);
        step();
        check("b2b_done", 128'(cdb_select_flag), 128'd0);

        // Flush with buffers 0 and 2 full (rr_ptr=3, so FU0 is granted during flush)
        set_fu(0, 1'b1, 5'd4, 32'h40);
        set_fu(2, 1'b1, 5'd6, 32'h60);
        step();
        fu_valid = 4'b0000;
        flush    = 1'b1;
        set_fu(1, 1'b1, 5'd8, 32'h80);
        #1;
        check("flush_ready", 128'(fu_ready), 128'd0);
        check("flush_flag",  128'(cdb_select_flag), 128'd1);
        check("flush_sel",   128'(cdb_select_signal), 128'd0);
        step();
        flush    = 1'b0;
        fu_valid = 4'b0000;
        #1;
        check("post_flush_flag",  128'(cdb_select_flag), 128'd0);
        check("post_flush_ready", 128'(fu_ready), 128'hF);
        set_fu(0, 1'b1, 5'd15, 32'hF0);
        step();
        fu_valid = 4'b0000;
        check("post_flush_sel", 128'(cdb_select_signal), 128'd0);
        check("post_flush_tag", 128'(cdb_rob_tag), 128'd15);
        step();
        check("post_flush_done", 128'(cdb_select_flag), 128'd0);

        // Asynchronous reset mid-operation drops the buffered result immediately
        set_fu(1, 1'b1, 5'd30, 32'h77);
        step();
        fu_valid = 4'b0000;
        check("mid_rst_pre", 128'(cdb_select_flag), 128'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_flag", 128'(cdb_select_flag), 128'd0);
        check("mid_rst_tag",  128'(cdb_rob_tag), 128'd0);
        check("mid_rst_vals", cdb_values, 128'd0);
        reset_n = 1'b1;
        step();
        check("mid_rst_idle", 128'(cdb_select_flag), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
